// File: rtl/pspin_pkt_alloc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pspin_pkt_alloc                                                            |
// | Ring-buffer packet allocator: aligned region carve-out, in-order reclaim.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pspin_pkt_alloc #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    LEN_WIDTH    = 20,
  parameter int                    TAG_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] BUF_BASE     = '0,
  parameter int                    BUF_SIZE     = 32768,
  parameter int                    ALIGN        = 64,
  parameter int                    MAX_INFLIGHT = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [LEN_WIDTH-1:0]            s_alloc_len,
  input  logic [TAG_WIDTH-1:0]            s_alloc_tag,
  input  logic                            s_alloc_valid,
  output logic                            s_alloc_ready,
  output logic [ADDR_WIDTH-1:0]           m_desc_addr,
  output logic [LEN_WIDTH-1:0]            m_desc_len,
  output logic [TAG_WIDTH-1:0]            m_desc_tag,
  output logic                            m_desc_valid,
  input  logic                            m_desc_ready,
  input  logic [ADDR_WIDTH-1:0]           s_free_addr,
  input  logic                            s_free_valid,
  output logic                            s_free_ready,
  output logic [ADDR_WIDTH-1:0]           stat_used,
  output logic [$clog2(MAX_INFLIGHT):0]   stat_inflight,
  output logic                            err_oversize,
  output logic                            err_free_order
);

  localparam int CW = $clog2(MAX_INFLIGHT) + 1;
  localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int WW = ((ADDR_WIDTH > LEN_WIDTH + 1) ? ADDR_WIDTH : LEN_WIDTH + 1) + 2;
  localparam logic [WW-1:0]        C_SIZE     = WW'(BUF_SIZE);
  localparam logic [LEN_WIDTH:0]   C_ALIGN_M1 = (LEN_WIDTH + 1)'(ALIGN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [LEN_WIDTH-1:0]   r_len;
  logic [TAG_WIDTH-1:0]   r_tag;
  logic [ADDR_WIDTH-1:0]  r_head;
  logic [ADDR_WIDTH-1:0]  r_used;
  logic [CW-1:0]          r_count;
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [ADDR_WIDTH-1:0]  r_fifo_off  [MAX_INFLIGHT];
  logic [ADDR_WIDTH-1:0]  r_fifo_span [MAX_INFLIGHT];

  logic [LEN_WIDTH:0]     w_round;
  logic [WW-1:0]          w_round_w;
  logic [WW-1:0]          w_head_w;
  logic                   w_fits;
  logic [WW-1:0]          w_place;
  logic [WW-1:0]          w_span;
  logic [WW-1:0]          w_end;
  logic [ADDR_WIDTH-1:0]  w_head_nxt;
  logic                   w_reject;
  logic                   w_room;
  logic                   w_commit;
  logic                   w_alloc_hs;
  logic                   w_free_hs;
  logic                   w_free_bad;
  logic [ADDR_WIDTH-1:0]  w_add;
  logic [ADDR_WIDTH-1:0]  w_sub;

  // Rounding is one bit wider than the length so a near-max length cannot wrap.
  assign w_round   = ({1'b0, r_len} + C_ALIGN_M1) & ~C_ALIGN_M1;
  assign w_round_w = WW'(w_round);
  assign w_head_w  = WW'(r_head);
  assign w_fits    = (w_head_w + w_round_w) <= C_SIZE;
  assign w_place   = w_fits ? w_head_w : '0;
  // A wrapped region also reserves the unusable tail so reclaim stays contiguous.
  assign w_span    = w_fits ? w_round_w : (C_SIZE - w_head_w) + w_round_w;
  assign w_end     = w_place + w_round_w;
  assign w_head_nxt = (w_end == C_SIZE) ? '0 : ADDR_WIDTH'(w_end);
  assign w_reject  = (r_len == '0) || (w_round_w > C_SIZE);
  assign w_room    = ((WW'(r_used) + w_span) <= C_SIZE) && (r_count < CW'(MAX_INFLIGHT));
  assign w_commit  = (r_state == S_CHECK) && !w_reject && w_room;

  assign s_free_ready = (r_count != '0);
  assign w_free_hs    = s_free_valid && s_free_ready;
  assign w_free_bad   = s_free_addr != (BUF_BASE + r_fifo_off[r_rd_ptr]);
  assign w_alloc_hs   = s_alloc_valid && s_alloc_ready;
  assign w_add        = w_commit  ? ADDR_WIDTH'(w_span)   : '0;
  assign w_sub        = w_free_hs ? r_fifo_span[r_rd_ptr] : '0;

  assign stat_used     = r_used;
  assign stat_inflight = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    s_alloc_ready = 1'b0;
    m_desc_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        s_alloc_ready = !rst;
        if (s_alloc_valid && !rst) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (w_reject || w_commit) w_state_nxt = w_reject ? S_IDLE : S_ISSUE;
      end
      S_ISSUE: begin
        m_desc_valid = 1'b1;
        if (m_desc_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len          <= '0;
      r_tag          <= '0;
      r_head         <= '0;
      r_used         <= '0;
      r_count        <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      m_desc_addr    <= '0;
      m_desc_len     <= '0;
      m_desc_tag     <= '0;
      err_oversize   <= 1'b0;
      err_free_order <= 1'b0;
    end else begin
      if (w_alloc_hs) begin
        r_len <= s_alloc_len;
        r_tag <= s_alloc_tag;
      end
      if (w_commit) begin
        r_head      <= w_head_nxt;
        r_wr_ptr    <= r_wr_ptr + PW'(1);
        m_desc_addr <= BUF_BASE + ADDR_WIDTH'(w_place);
        m_desc_len  <= r_len;
        m_desc_tag  <= r_tag;
      end
      if (w_free_hs) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_used  <= r_used + w_add - w_sub;
      r_count <= r_count + CW'(w_commit) - CW'(w_free_hs);
      if ((r_state == S_CHECK) && w_reject) err_oversize <= 1'b1;
      // The pop still happens on a mismatch; only the sticky flag records it.
      if (w_free_hs && w_free_bad) err_free_order <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_fifo_off[r_wr_ptr]  <= ADDR_WIDTH'(w_place);
      r_fifo_span[r_wr_ptr] <= ADDR_WIDTH'(w_span);
    end
  end

endmodule
`default_nettype wire

// File: doc/pspin_pkt_alloc.md
# pspin_pkt_alloc

Ring-buffer packet allocator for the PsPIN ingress path. It sits between the matching engine and the ingress DMA engine. It accepts one allocation request per matched frame (length and tag), carves an aligned contiguous region out of the PsPIN packet buffer, and issues the write descriptor (address, length, tag) that sequences the DMA. It reclaims regions when PsPIN reports packets consumed, in allocation order, and exposes occupancy and sticky error status for control registers.

## Interface
Parameters:
- ADDR_WIDTH, 32, packet buffer address width
- LEN_WIDTH, 20, frame length width (bytes)
- TAG_WIDTH, 32, opaque tag width
- BUF_BASE, 32'h0, byte address of packet buffer start
- BUF_SIZE, 32768, buffer size in bytes; multiple of ALIGN
- ALIGN, 64, allocation granularity in bytes; power of two
- MAX_INFLIGHT, 16, max outstanding allocations (span FIFO depth); power of two

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- s_alloc_len  in  LEN_WIDTH  frame length in bytes
- s_alloc_tag  in  TAG_WIDTH  frame tag
- s_alloc_valid / s_alloc_ready  in / out  1  request handshake
- m_desc_addr  out  ADDR_WIDTH  write descriptor address to ingress DMA
- m_desc_len  out  LEN_WIDTH  write descriptor length (unrounded)
- m_desc_tag  out  TAG_WIDTH  write descriptor tag
- m_desc_valid / m_desc_ready  out / in  1  descriptor handshake
- s_free_addr  in  ADDR_WIDTH  address of consumed packet
- s_free_valid / s_free_ready  in / out  1  free handshake
- stat_used  out  ADDR_WIDTH  bytes reserved, including wrap gaps
- stat_inflight  out  $clog2(MAX_INFLIGHT)+1  outstanding allocations
- err_oversize  out  1  sticky: rejected request
- err_free_order  out  1  sticky: free address mismatch

## Operation
- State: head offset H, used bytes U, count C, span FIFO of {offset, span} entries.
- Rounding: R = (len + ALIGN-1) & ~(ALIGN-1), computed at LEN_WIDTH+1 bits so that no overflow occurs.
- FSM IDLE:
  - s_alloc_ready=1.
  - On handshake, latch len and tag, then go to CHECK.
- FSM CHECK:
  - s_alloc_ready=0.
  - If len==0 or R>BUF_SIZE: set err_oversize, issue no descriptor, go to IDLE.
  - Placement: if H+R <= BUF_SIZE, place at H with span=R. Otherwise place at 0 with span=(BUF_SIZE-H)+R.
  - Commit requires U+span <= BUF_SIZE and C < MAX_INFLIGHT, evaluated on registered U and C. Otherwise stay in CHECK.
  - On commit:
    - push {place, span};
    - U+=span; C+=1;
    - H=place+R, with H=0 when it equals BUF_SIZE;
    - load m_desc_addr=BUF_BASE+place, m_desc_len=len, m_desc_tag=tag;
    - go to ISSUE.
- FSM ISSUE:
  - m_desc_valid=1, with all m_desc fields held stable.
  - On m_desc_ready, go to IDLE.
- Free:
  - s_free_ready = (C != 0), independent of FSM state.
  - On handshake, pop the FIFO head, U-=span, C-=1.
  - If s_free_addr != BUF_BASE+head offset, set err_free_order. The pop still occurs.
- Simultaneous commit and free: U = U + span_new - span_freed, and C is unchanged.
- Error flags clear only on rst.
- stat_used = U and stat_inflight = C, both registered.

## Timing
- Reset values: all outputs 0, including m_desc_*. FSM returns to IDLE, H=U=C=0, FIFO empty.
- rst asserted mid-ISSUE drops m_desc_valid immediately (asynchronous).
- Latency with space available: request accepted in cycle N, CHECK in N+1, m_desc_valid high in N+2.
- Throughput: at most one request per 3 cycles.
- Stalled CHECK: a free handshake in cycle M enables commit at the earliest in M+1, with m_desc_valid in M+2.
- Rejected request: accepted in N, err_oversize high in N+2, s_alloc_ready high again in N+2.
- Free path: 1-cycle update of stat_used and stat_inflight after the handshake.
- AXI-Stream handshake rules apply: valid never depends on ready, and payload holds while valid && !ready.

## Test plan
BUF_BASE=0x1000_0000, BUF_SIZE=4096, ALIGN=64, MAX_INFLIGHT=4.
- Basic allocation: after reset, request len=100, tag=0xA.
  - m_desc addr=0x1000_0000, len=100, tag=0xA, valid 2 cycles after accept.
  - stat_used=128, stat_inflight=1.
- Wrap-around: allocate 3×1024 (H=3072), free 0x1000_0000 and 0x1000_0400, then request len=1500.
  - Descriptor addr=0x1000_0000, len=1500.
  - stat_used=3584, stat_inflight=2, H=1536.
- Inflight limit: four len=64 requests, then a fifth.
  - The fifth waits in CHECK with s_alloc_ready=0.
  - Free 0x1000_0000 -> descriptor addr=0x1000_0100 issued 2 cycles after the free handshake.
- Rejection: request len=5000, then len=0.
  - No m_desc_valid for either.
  - err_oversize=1 and stays set; stat_used unchanged.
- Free ordering: after two allocations (0x1000_0000, 0x1000_0040), free 0x1000_0040 first.
  - err_free_order=1, stat_inflight=1, stat_used=64.
- Concurrency and reset: a free handshake in the same cycle as a commit leaves stat_used = old + span_new - span_freed.
  - Asserting rst while m_desc_valid=1 clears every output asynchronously.
